// File: rtl/agc_out_checker.sv
// agc_out_checker: compares the AGC output sample stream against a buffered reference stream over one frame
// Ports: clk, reset (async active-low); start pulse; smp_en/smp_data AGC samples;
// exp_valid/exp_data/exp_ready reference stream; busy/done/pass status;
// err_count, first_err_vld/first_err_idx, underrun error reporting.
module agc_out_checker #(
  parameter int DATA_W     = 39,
  parameter int FRAME_LEN  = 100000,
  parameter int CNT_W      = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              smp_en,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_vld,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  logic [CNT_W-1:0] idx;
  logic clr, smp, push, pop, empty, err, last;
  assign clr = start && state != RUN;
  assign smp = state == RUN && smp_en;
  assign empty = occ == '0;
  assign push = exp_valid && exp_ready;
  assign pop = smp && !empty;
  // empty is checked on start-of-cycle occupancy, so a same-cycle push never rescues a sample
  assign err = smp && (empty || mem[rd_ptr] != smp_data);
  assign last = smp && idx == CNT_W'(FRAME_LEN - 1);
  assign exp_ready = state == RUN && occ < (AW+1)'(FIFO_DEPTH);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0 && !underrun;
  always_comb state_nxt = clr ? RUN : last ? DONE : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= exp_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      idx <= '0;
      err_count <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      underrun <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      idx <= '0;
      err_count <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (smp) idx <= idx + 1'b1;
      if (smp && empty) underrun <= 1'b1;
      if (err) begin
        err_count <= err_count + CNT_W'(!(&err_count));
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_idx <= idx;
        end
      end
    end
endmodule

// File: tb/tb_agc_out_checker.sv
// tb_agc_out_checker: scoreboard bench for agc_out_checker with a small frame and a 4-deep FIFO
module tb_agc_out_checker;
  localparam int DW = 39, FL = 8, CW = 17, FD = 4;
  logic clk = 0, reset = 1, start = 0, smp_en = 0, exp_valid = 0;
  logic [DW-1:0] smp_data = '0, exp_data = '0;
  logic exp_ready, busy, done, pass, first_err_vld, underrun;
  logic [CW-1:0] err_count, first_err_idx;
  int tests = 0, fails = 0;
  logic [DW-1:0] ref_w [16];
  logic [DW-1:0] m_q [$];
  int m_state, m_idx;
  logic [CW-1:0] m_err, m_fidx;
  logic m_fv, m_under;
  agc_out_checker #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .smp_en(smp_en), .smp_data(smp_data),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_vld(first_err_vld),
    .first_err_idx(first_err_idx), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0;
    m_q.delete();
    m_idx = 0;
    m_err = '0;
    m_fv = 0;
    m_fidx = '0;
    m_under = 0;
  endtask
  task automatic model_step();
    logic rdy, bad;
    logic [DW-1:0] h;
    rdy = m_state == 1 && m_q.size() < FD;
    if (start && m_state != 1) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1) begin
      if (smp_en) begin
        bad = 0;
        if (m_q.size() == 0) begin
          m_under = 1;
          bad = 1;
        end else begin
          h = m_q.pop_front();
          bad = h != smp_data;
        end
        if (bad) begin
          if (m_err != '1) m_err = m_err + 1'b1;
          if (!m_fv) begin
            m_fv = 1;
            m_fidx = CW'(m_idx);
          end
        end
        if (m_idx == FL - 1) m_state = 2;
        m_idx++;
      end
      if (exp_valid && rdy) m_q.push_back(exp_data);
    end
  endtask
  task automatic cmp_all();
    chk("exp_ready", exp_ready, m_state == 1 && m_q.size() < FD);
    chk("busy", busy, m_state == 1);
    chk("done", done, m_state == 2);
    chk("pass", pass, m_state == 2 && m_err == 0 && !m_under);
    chk("err_count", err_count, m_err);
    chk("first_err_vld", first_err_vld, m_fv);
    chk("first_err_idx", first_err_idx, m_fidx);
    chk("underrun", underrun, m_under);
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_exp_ready"}, exp_ready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_pass"}, pass, 0);
    chk({p, "_err_count"}, err_count, 0);
    chk({p, "_first_err_vld"}, first_err_vld, 0);
    chk({p, "_first_err_idx"}, first_err_idx, 0);
    chk({p, "_underrun"}, underrun, 0);
  endtask
  task automatic cyc(input logic st, input logic se, input logic [DW-1:0] sd, input logic ev, input logic [DW-1:0] ed);
    @(negedge clk);
    cmp_all();
    start = st;
    smp_en = se;
    smp_data = sd;
    exp_valid = ev;
    exp_data = ed;
    model_step();
  endtask
  task automatic idle();
    cyc(0, 0, '0, 0, '0);
  endtask
  task automatic run_frame(input int lead, input int bad);
    for (int i = 0; i < lead; i++) cyc(0, 0, '0, 1, ref_w[i]);
    for (int k = 0; k < FL; k++)
      cyc(0, 1, k == bad ? DW'(1) : ref_w[k], k + lead < FL, ref_w[k + lead]);
    idle();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) ref_w[i] = DW'({$urandom(), $urandom()});
    #1 reset = 0;
    #1 chk_zero("rst");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    idle();
    idle();
    chk("idle_busy", busy, 0);
    cyc(1, 0, '0, 0, '0);
    run_frame(2, -1);
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);
    chk("clean_busy", busy, 0);
    ref_w[5] = '0;
    cyc(1, 0, '0, 0, '0);
    idle();
    chk("mm_busy", busy, 1);
    run_frame(2, 5);
    chk("mm_err", err_count, 1);
    chk("mm_fv", first_err_vld, 1);
    chk("mm_fidx", first_err_idx, 5);
    chk("mm_pass", pass, 0);
    cyc(1, 0, '0, 0, '0);
    cyc(0, 1, ref_w[0], 1, ref_w[0]);
    idle();
    chk("ur_underrun", underrun, 1);
    chk("ur_err_ge1", err_count != 0, 1);
    chk("ur_fidx", first_err_idx, 0);
    for (int k = 1; k < FL; k++) cyc(0, 1, ref_w[k-1], 1, ref_w[k]);
    idle();
    chk("ur_done", done, 1);
    chk("ur_pass", pass, 0);
    chk("ur_err", err_count, 1);
    cyc(1, 0, '0, 0, '0);
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1, ref_w[i]);
    idle();
    chk("bp_full_ready", exp_ready, 0);
    cyc(0, 1, ref_w[0], 0, '0);
    idle();
    chk("bp_ready_after_pop", exp_ready, 1);
    cyc(1, 1, ref_w[1], 0, '0);
    cyc(0, 1, ref_w[2], 0, '0);
    chk("start_ignored_busy", busy, 1);
    chk("start_ignored_err", err_count, 0);
    for (int k = 3; k < FL; k++) cyc(0, 1, ref_w[k], 0, '0);
    idle();
    chk("bp_err", err_count, 4);
    chk("bp_fidx", first_err_idx, 4);
    chk("bp_underrun", underrun, 1);
    chk("bp_done", done, 1);
    cyc(1, 0, '0, 0, '0);
    idle();
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_fv", first_err_vld, 0);
    chk("restart_underrun", underrun, 0);
    cyc(0, 1, '0, 0, '0);
    cyc(0, 1, '0, 0, '0);
    cyc(0, 0, '0, 1, ref_w[0]);
    cyc(0, 1, ref_w[0], 0, '0);
    @(negedge clk);
    cmp_all();
    chk("pre_rst_err", err_count, 2);
    smp_en = 0;
    exp_valid = 0;
    #2 reset = 0;
    #1 chk_zero("midrst");
    model_reset();
    @(negedge clk);
    reset = 1;
    idle();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    ref_w[2] = '0;
    cyc(1, 0, '0, 0, '0);
    run_frame(1, 2);
    chk("post_rst_fidx", first_err_idx, 2);
    chk("post_rst_err", err_count, 1);
    chk("post_rst_done2", done, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/agc_out_checker.md
# agc_out_checker

In-fabric response checker at the output of the AGC datapath. It consumes the AGC output sample stream (`out_agc`, sfix39_En36, qualified by `clk_enable`) and compares each sample against a reference stream delivered over a ready/valid interface from a memory reader. It holds reference words in a small elastic FIFO, counts samples up to a frame length, and reports pass/fail, error count and first-mismatch index. It is the hardware counterpart of the stimulus side: the stimulus side drives the AGC, and this block judges the AGC's output.

## Interface
- `DATA_W`, 39: sample and reference width, matching the AGC output format sfix39_En36.
- `FRAME_LEN`, 100000: samples per check frame.
- `CNT_W`, 17: width of the index and error counters; must satisfy 2^CNT_W > FRAME_LEN.
- `FIFO_DEPTH`, 4: reference FIFO entries; power of two, at least 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start pulse; honoured only in IDLE or DONE.
- `smp_en`  in  1  AGC output sample valid (the AGC `clk_enable`); cannot be stalled.
- `smp_data`  in  DATA_W  AGC output sample.
- `exp_valid`  in  1  reference word valid.
- `exp_data`  in  DATA_W  reference word.
- `exp_ready`  out  1  reference FIFO can accept a word.
- `busy`  out  1  state is RUN.
- `done`  out  1  frame complete; held until the next start.
- `pass`  out  1  set in DONE only, when `err_count`==0 and `underrun`==0.
- `err_count`  out  CNT_W  mismatches plus underruns; saturates at all-ones.
- `first_err_vld`  out  1  `first_err_idx` is valid.
- `first_err_idx`  out  CNT_W  sample index of the first error.
- `underrun`  out  1  sticky; a sample arrived while the FIFO was empty.

## Operation
- **States.** IDLE → RUN → DONE → (start) → RUN. Reset enters IDLE.
- **start in IDLE or DONE:**
  - Clears the sample index, `err_count`, `first_err_vld`, `first_err_idx`, `underrun`, `done`, `pass` and the FIFO pointers.
  - Enters RUN on the next cycle.
- **start in RUN:** ignored.
- **exp_ready:** equals (state==RUN) and (occupancy < FIFO_DEPTH). It comes from registers only and has no combinational path from `exp_valid` or `smp_en`.
- **Push:** a push happens when `exp_valid` and `exp_ready` are both high.
- **Sample handling in RUN,** on each `smp_en`, using the FIFO occupancy at the start of the cycle (no same-cycle bypass):
  - **Occupancy > 0:** pop the head and compare it with `smp_data` by exact bitwise equality over DATA_W. On inequality, record an error.
  - **Occupancy == 0:** set `underrun`, record an error, do not pop.
  - **Recording an error:** `err_count`+1 (saturating). If `first_err_vld`==0, set `first_err_vld` and load `first_err_idx` with the current index.
  - **Index:** increments by 1 per `smp_en`.
- **Simultaneous push and pop:** occupancy is unchanged. The popped entry is the old head. A push into an empty FIFO in the same cycle as `smp_en` still counts as an underrun.
- **Frame end:** the sample accepted at index FRAME_LEN-1 moves the state to DONE. The index does not wrap.
- **smp_en outside RUN:** ignored, with no counting.
- **DONE:**
  - `exp_ready`=0.
  - Leftover FIFO entries are discarded at the next start.
  - `pass` = (`err_count`==0) and (`underrun`==0).

## Timing
- **Reset values:** all outputs 0 (`exp_ready`, `busy`, `done`, `pass`, `err_count`, `first_err_vld`, `first_err_idx`, `underrun`). State IDLE, FIFO empty.
- **Reset mid-frame:** asynchronous deassertion of activity. Outputs go to their reset values immediately, and the frame is abandoned.
- **start to busy:** start at edge N gives `busy`=1 and `exp_ready`=1 after edge N+1.
- **Error latency:** `err_count`, `first_err_*` and `underrun` update at the edge that samples the offending `smp_en`, visible one cycle after it.
- **Frame-end latency:** `done` and `pass` are valid one cycle after the final sample's edge, together with the `busy` fall.
- **FIFO latency:** a word pushed at edge N can be popped by `smp_en` at edge N+1 or later.
- **Throughput:** `smp_en` may be high every cycle. The reference supplier must stay one word ahead to avoid underrun.

## Test plan
- **Clean frame:**
  - Stimulus: FRAME_LEN=8. Reference is preloaded two words ahead. `smp_en` every cycle, with `smp_data` equal to the reference.
  - Required: `done`=1, `pass`=1, `err_count`=0, `busy` low one cycle after the 8th sample.
- **Single mismatch:**
  - Stimulus: sample index 5 = 39'h00_0000_0001, reference = 39'h0.
  - Required: `err_count`=1, `first_err_vld`=1, `first_err_idx`=5, `pass`=0.
- **Underrun:**
  - Stimulus: `smp_en` at index 0 with `exp_valid` first asserted in the same cycle.
  - Required: `underrun`=1, `err_count`≥1, `first_err_idx`=0.
- **Backpressure:**
  - Stimulus: FIFO_DEPTH=4, `exp_valid` held high, no `smp_en`.
  - Required: exactly 4 pushes, then `exp_ready`=0. One `smp_en` gives `exp_ready`=1 on the next cycle.
- **Start ignored, then restart:**
  - Stimulus: start pulsed in RUN, then again after DONE.
  - Required: the first pulse has no effect. The second clears the counters and `done`, and `busy`=1 next cycle.
- **Reset mid-frame:**
  - Stimulus: `reset` low at index 3 with `err_count`=2.
  - Required: all outputs 0 immediately. After release the state is IDLE, and start begins from index 0.
